// File: rtl/srm_mem_pkg.sv
// Shared types and widths for the SRM external memory controller.
package srm_mem_pkg;
  localparam int SRM_ADDR_W = 22;
  localparam int SRM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  // Wait counter must hold WAIT_STATES; never narrower than one bit.
  function automatic int cnt_width(input int ws);
    return (ws < 1) ? 1 : $clog2(ws + 1);
  endfunction
endpackage

// File: rtl/srm_wait_cnt.sv
// Loadable down-counter that stops at zero; zero flag marks terminal count.
module srm_wait_cnt #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/srm_mem_ctrl.sv
// SRAM-style memory controller: one word per request, programmable wait states.
//
//  state  | meaning
//  IDLE   | waiting for mr; accepts a request and latches address/data/direction
//  ACCESS | strobes active, wait counter running; read data captured on the last cycle
//  DONE   | strobes released, En high for one cycle so the core consumes the result
module srm_mem_ctrl
  import srm_mem_pkg::*;
#(
  parameter int ADDR_W      = SRM_ADDR_W,
  parameter int DATA_W      = SRM_DATA_W,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              Res,
  input  logic              mr,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] D_out,
  output logic [DATA_W-1:0] D_in,
  output logic              En,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  output logic              ext_cs_n,
  output logic              ext_oe_n,
  output logic              ext_we_n
);

  localparam int CNT_W = cnt_width(WAIT_STATES);
  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

  mem_state_t       state;
  logic             we_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             start;

  assign start = (state == IDLE) && mr;

  srm_wait_cnt #(.WIDTH(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .rst_b    (Res),
    .load     (start),
    .load_val (WS_LOAD),
    .dec      (state == ACCESS),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // Strobes are registered on entry to / exit from ACCESS so they track the state exactly.
  always_ff @(posedge clk) begin
    if (!Res) begin
      state     <= IDLE;
      D_in      <= '0;
      ext_addr  <= '0;
      ext_wdata <= '0;
      we_q      <= 1'b0;
      ext_cs_n  <= 1'b1;
      ext_oe_n  <= 1'b1;
      ext_we_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (mr) begin
            ext_addr  <= Address;
            ext_wdata <= D_out;
            we_q      <= mem_we;
            ext_cs_n  <= 1'b0;
            ext_oe_n  <= mem_we;
            ext_we_n  <= ~mem_we;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            if (!we_q) D_in <= ext_rdata;
            ext_cs_n <= 1'b1;
            ext_oe_n <= 1'b1;
            ext_we_n <= 1'b1;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign En = (state == DONE) || ((state == IDLE) && !mr);

endmodule
